// File: rtl/word_pkg.sv
// word_pkg: shared constants for the word collector slice.
//   WORD_W_DEFAULT  default word width, matches the gearbox output width
//   DEPTH_DEFAULT   default FIFO depth in words
//   LANE0_FIRST / LANE1_FIRST  encodings of in_lane1_first
package word_pkg;

    localparam int   WORD_W_DEFAULT = 10;
    localparam int   DEPTH_DEFAULT  = 8;

    localparam logic LANE0_FIRST    = 1'b0;
    localparam logic LANE1_FIRST    = 1'b1;

endpackage : word_pkg

// File: rtl/word_order_mux.sv
// word_order_mux: restores stream order between the two gearbox lanes.
// Ports:
//   data0/valid0  lane-0 word and valid
//   data1/valid1  lane-1 word and valid
//   lane1_first   with both lanes valid, 1 means lane 1 carries the older word
//   older_data    word to be written first (at wr_ptr)
//   younger_data  word to be written second (at wr_ptr+1), only when push_cnt=2
//   push_cnt      number of words offered this cycle, 0..2
module word_order_mux
    import word_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic [WORD_W-1:0] data0,
    input  logic              valid0,
    input  logic [WORD_W-1:0] data1,
    input  logic              valid1,
    input  logic              lane1_first,
    output logic [WORD_W-1:0] older_data,
    output logic [WORD_W-1:0] younger_data,
    output logic [1:0]        push_cnt
);

    // Select older/younger words from the lane valids and the order flag.
    always_comb begin
        older_data   = data0;
        younger_data = data1;
        push_cnt     = 2'd0;
        case ({valid1, valid0})
            2'b11: begin
                push_cnt = 2'd2;
                if (lane1_first == LANE1_FIRST) begin
                    older_data   = data1;
                    younger_data = data0;
                end else begin
                    older_data   = data0;
                    younger_data = data1;
                end
            end
            2'b01: begin
                push_cnt   = 2'd1;
                older_data = data0;
            end
            2'b10: begin
                push_cnt   = 2'd1;
                older_data = data1;
            end
            default: begin
                push_cnt = 2'd0;
            end
        endcase
    end

endmodule : word_order_mux

// File: rtl/word_collector.sv
// word_collector: merges the two gearbox output lanes into one ordered
// stream buffered in a circular FIFO, drained one word per cycle.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_data0/in_valid0       lane-0 word and valid
//   in_data1/in_valid1       lane-1 word and valid
//   in_lane1_first           order of the lanes when both are valid
//   out_data/out_valid       head-of-FIFO word and presence
//   out_ready                consumer accepts the head word
//   count                    occupancy 0..DEPTH
//   full                     count == DEPTH
//   overflow                 sticky, set when any offered word was dropped
module word_collector
    import word_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data0,
    input  logic              in_valid0,
    input  logic [WORD_W-1:0] in_data1,
    input  logic              in_valid1,
    input  logic              in_lane1_first,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;

    logic [WORD_W-1:0] older_s;
    logic [WORD_W-1:0] younger_s;
    logic [1:0]        push_cnt_s;
    logic [CNT_W-1:0]  free_s;
    logic [1:0]        accept_s;
    logic              drop_s;
    logic              pop_s;

    word_order_mux #(
        .WORD_W (WORD_W)
    ) u_order (
        .data0        (in_data0),
        .valid0       (in_valid0),
        .data1        (in_data1),
        .valid1       (in_valid1),
        .lane1_first  (in_lane1_first),
        .older_data   (older_s),
        .younger_data (younger_s),
        .push_cnt     (push_cnt_s)
    );

    // Accepted pushes are limited by the space left before this cycle's pop;
    // a simultaneous pop never makes room for the current pushes.
    always_comb begin
        free_s   = CNT_W'(DEPTH) - count_r;
        accept_s = 2'd0;
        if (free_s >= CNT_W'(2)) begin
            accept_s = push_cnt_s;
        end else if (free_s == CNT_W'(1)) begin
            accept_s = (push_cnt_s != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            accept_s = 2'd0;
        end
        drop_s = (accept_s != push_cnt_s);
        pop_s  = (count_r != CNT_W'(0)) && out_ready;
    end

    // Word storage; contents are not reset, only the pointers and count are.
    always_ff @(posedge clk) begin
        if (!rst && (accept_s != 2'd0)) begin
            mem_r[wr_ptr_r] <= older_s;
        end
        if (!rst && (accept_s == 2'd2)) begin
            mem_r[wr_ptr_r + PTR_W'(1)] <= younger_s;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(accept_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
            count_r  <= count_r + CNT_W'(accept_s) - CNT_W'(pop_s);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign out_data  = mem_r[rd_ptr_r];
    assign out_valid = (count_r != CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));
    assign count     = count_r;
    assign overflow  = overflow_r;

endmodule : word_collector

// File: tb/tb_word_collector.sv
// tb_word_collector: directed and randomized stimulus for word_collector,
// checked cycle by cycle against a queue-based reference model.
module tb_word_collector;

    localparam int WORD_W = 10;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [WORD_W-1:0] in_data0, in_data1;
    logic              in_valid0, in_valid1, in_lane1_first;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WORD_W-1:0] model_q[$];
    logic [WORD_W-1:0] popped_q[$];
    logic              model_ovf = 1'b0;
    logic              model_known = 1'b0;

    word_collector #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data0       (in_data0),
        .in_valid0      (in_valid0),
        .in_data1       (in_data1),
        .in_valid1      (in_valid1),
        .in_lane1_first (in_lane1_first),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .full           (full),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every DUT output against the model state.
    task automatic check_state();
        check_eq("count", 32'(count), 32'(model_q.size()));
        check_eq("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        check_eq("full", 32'(full), 32'(model_q.size() == DEPTH));
        check_eq("overflow", 32'(overflow), 32'(model_ovf));
        if (model_q.size() != 0) begin
            check_eq("out_data", 32'(out_data), 32'(model_q[0]));
        end
    endtask

    // One clock: drive inputs, check outputs, clock edge, update model.
    task automatic step(input logic v0, input logic [WORD_W-1:0] d0,
                        input logic v1, input logic [WORD_W-1:0] d1,
                        input logic l1f, input logic rdy, input logic r);
        int free;
        logic [WORD_W-1:0] offer[$];
        rst = r; in_valid0 = v0; in_data0 = d0; in_valid1 = v1; in_data1 = d1;
        in_lane1_first = l1f; out_ready = rdy;
        if (model_known) check_state();
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_ovf   = 1'b0;
            model_known = 1'b1;
        end else begin
            free = DEPTH - model_q.size();
            if (v0 && v1) begin
                if (l1f) begin offer.push_back(d1); offer.push_back(d0); end
                else     begin offer.push_back(d0); offer.push_back(d1); end
            end else if (v0) offer.push_back(d0);
            else if (v1) offer.push_back(d1);
            if (model_q.size() != 0 && rdy) popped_q.push_back(model_q.pop_front());
            foreach (offer[i]) begin
                if (i < free) model_q.push_back(offer[i]);
                else model_ovf = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, 1'b0, '0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 10'h3ff, 1'b1, 10'h3fe, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [WORD_W-1:0] w;
        int k;
        do_reset();
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);

        // Single push with 1-cycle latency.
        step(1'b1, 10'h155, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        check_eq("single_valid", 32'(out_valid), 32'd1);
        check_eq("single_data", 32'(out_data), 32'h155);
        idle(1'b1);
        check_eq("single_drain", 32'(count), 32'd0);

        // Dual push ordering, both flag values.
        for (int f = 1; f >= 0; f--) begin
            popped_q.delete();
            step(1'b1, 10'h001, 1'b1, 10'h002, f[0], 1'b0, 1'b0);
            idle(1'b1); idle(1'b1);
            check_eq("dual_n", 32'(popped_q.size()), 32'd2);
            if (popped_q.size() == 2) begin
                check_eq("dual_first", 32'(popped_q[0]), f ? 32'h002 : 32'h001);
                check_eq("dual_second", 32'(popped_q[1]), f ? 32'h001 : 32'h002);
            end
        end

        // Gearbox 8-words-per-5-cycles pattern, ascending values.
        popped_q.delete();
        step(1'b1, 10'd0, 1'b1, 10'd1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 10'd0, 1'b1, 10'd2, 1'b0, 1'b1, 1'b0);
        step(1'b1, 10'd4, 1'b1, 10'd3, 1'b1, 1'b1, 1'b0);
        step(1'b1, 10'd5, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 10'd6, 1'b1, 10'd7, 1'b0, 1'b1, 1'b0);
        check_eq("gear_residual", 32'(count >= 1), 32'd1);
        check_eq("gear_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) idle(1'b1);
        check_eq("gear_n", 32'(popped_q.size()), 32'd8);
        foreach (popped_q[i]) check_eq("gear_order", 32'(popped_q[i]), 32'(i));

        // Fill with four dual pushes, then overflow on a further push.
        for (int i = 0; i < 4; i++)
            step(1'b1, 10'(16 + 2*i), 1'b1, 10'(17 + 2*i), 1'b0, 1'b0, 1'b0);
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_count", 32'(count), 32'd8);
        step(1'b1, 10'h2aa, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("fill_ovf", 32'(overflow), 32'd1);
        check_eq("fill_count2", 32'(count), 32'd8);
        popped_q.delete();
        for (int i = 0; i < 9; i++) idle(1'b1);
        foreach (popped_q[i]) check_eq("fill_data", 32'(popped_q[i]), 32'(16 + i));

        // count=7, dual push plus pop: only the older word is kept.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 10'(32 + i), 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 10'h0a1, 1'b1, 10'h0b2, 1'b1, 1'b1, 1'b0);
        check_eq("edge_count", 32'(count), 32'd7);
        check_eq("edge_ovf", 32'(overflow), 32'd1);
        popped_q.delete();
        for (int i = 0; i < 7; i++) idle(1'b1);
        check_eq("edge_last", 32'(popped_q[6]), 32'h0b2);

        // Wrap with random ready, then reset while data is buffered.
        do_reset();
        k = 0;
        while (k < 20) begin
            w = 10'($urandom_range(0, 1023));
            step(1'b1, w, 1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            k++;
        end
        idle(1'b0);
        check_eq("pre_rst_nonempty", 32'(count != 0), 32'd1);
        do_reset();
        check_eq("wr_count", 32'(count), 32'd0);
        check_eq("wr_valid", 32'(out_valid), 32'd0);
        check_eq("wr_ovf", 32'(overflow), 32'd0);
        popped_q.delete();
        step(1'b1, 10'h111, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check_eq("wr_first", 32'(popped_q.size() > 0 ? popped_q[0] : 10'h3ff), 32'h111);

        // Randomized traffic, occasional reset; model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 1)),
                 10'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
        end
        check_state();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_word_collector

// File: doc/word_collector.md
# word_collector

Downstream consumer of the 16-to-10 gearbox stage. Accepts up to two 10-bit words per cycle from the gearbox's two output lanes, restores stream order, and buffers them in a circular FIFO. Drains one word per cycle to the next stage through a valid/ready handshake. Absorbs the gearbox's bursty 8-words-per-5-cycles pattern so that downstream logic sees a single ordered word stream.

## Interface
- WORD_W, 10, word width in bits; matches the gearbox output width.
- DEPTH, 8, FIFO depth in words; power of two, at least 4.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived, not overridden).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data0  in  WORD_W  lane-0 word (gearbox buffer0).
- in_valid0  in  1  lane-0 word valid this cycle.
- in_data1  in  WORD_W  lane-1 word (gearbox buffer1).
- in_valid1  in  1  lane-1 word valid this cycle.
- in_lane1_first  in  1  when both lanes are valid: 1 means the lane-1 word is older; ignored otherwise.
- out_data  out  WORD_W  head-of-FIFO word.
- out_valid  out  1  head word present.
- out_ready  in  1  consumer accepts the word this cycle.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; a word was dropped.

## Operation
- Storage is a DEPTH-entry array with a write pointer wr_ptr and a read pointer rd_ptr, each log2(DEPTH) bits wide and wrapping naturally. The occupancy register is count.
- Push ordering:
  - If both lanes are valid, the older word goes to wr_ptr and the younger to wr_ptr+1. The older word is lane 1 if in_lane1_first=1, otherwise lane 0.
  - If only one lane is valid, its word goes to wr_ptr.
- Space check: free = DEPTH - count, evaluated before this cycle's pop. A pop in the same cycle does not create room for this cycle's pushes.
- Drop rules:
  - If free=1 and two words are offered, only the older word is written and overflow is set.
  - If free=0, all offered words are dropped and overflow is set when at least one lane is valid.
- Pop: occurs when out_valid && out_ready; rd_ptr advances by 1.
- Update: count_next = count + pushes_accepted - pop. wr_ptr advances by pushes_accepted (0, 1 or 2).
- Outputs:
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr].
  - full = (count == DEPTH).
  - All three are derived from registers, with no combinational path from the inputs.
- overflow is cleared only by rst.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, overflow=0; hence out_valid=0, full=0. Memory contents are not reset, and out_data is don't-care while out_valid=0.
- Reset mid-operation: everything buffered is discarded. Inputs present in the reset cycle are ignored.

## Timing
- A word written at edge N is visible on out_data/out_valid after edge N, so it can be popped at edge N+1. Minimum latency is 1 cycle.
- Throughput: 2 words in and 1 word out per cycle.
  - Sustained gearbox input averages 1.6 words per cycle, so the FIFO fills unless there is upstream idle time.
  - DEPTH is sized by the system for the burst length.
- out_data must remain stable while out_valid=1 and out_ready=0.
- Simultaneous push of 2 and pop of 1 with count=DEPTH-1: free=1, so only the older word is written, overflow is set, and count stays at DEPTH-1.
- Pointer wrap: a two-word write at wr_ptr=DEPTH-1 places the words at DEPTH-1 and 0.

## Structure
- Shared package word_pkg holds WORD_W_DEFAULT=10, and is the place for the lane-order encoding constants (LANE0_FIRST=0, LANE1_FIRST=1) if used.
- One natural sub-module, word_order_mux: a combinational block that takes both lanes plus in_lane1_first and produces older/younger words and a push count of 0..2.
- The FIFO core stays in word_collector.

## Test plan
- Reset, then a single push: in_valid0=1, in_data0=0x155, out_ready=1. Expect out_valid=1 with out_data=0x155 the next cycle, then count returns to 0.
- Dual push order: in_data0=0x001, in_data1=0x002, both valid.
  - With in_lane1_first=1, expect the pop sequence 0x002, 0x001.
  - Repeat with in_lane1_first=0: expect 0x001, 0x002.
- Replay of the 5-cycle gearbox pattern with ascending word values 0..7 and the correct lane-first flags, out_ready=1. Expect outputs 0..7 in order, no overflow, and at least 1 residual word in the FIFO.
- Fill with out_ready=0 using four dual pushes (DEPTH=8). Expect full=1 and count=8. A further push leaves count=8, sets overflow=1, and the contents are unchanged.
- Edge case: count=7, dual push plus pop. Expect only the older word stored, count=7, and overflow=1.
- Wrap and reset: run 20 words through with random out_ready, then assert rst while count>0. The next cycle expect count=0, out_valid=0 and overflow=0, and the words after reset emerge starting from the first post-reset input.
